// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and a
// parity helper. A future receiver is expected to import this package too.
// Optional feature macro: UART_TX_PARITY_EN (adds one even-parity bit per frame).
package uart_pkg;

    // Number of payload bits per frame.
    localparam int UART_DATA_BITS = 8;

    // Line level while no frame is being sent (also the stop-bit level).
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Transmitter FSM states. PARITY is only ever entered when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// rdata always shows the oldest entry while empty is low; pop consumes it.
// Pushes while full and pops while empty are ignored, so callers may drive
// push/pop straight from a valid signal without extra gating.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Accepted operations after full/empty protection.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; no reset so it can map onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO.
// Frame: start bit (low), 8 data bits LSB first, optional even-parity bit,
// one stop bit (high). Each bit lasts CLK_DIV clock cycles.
// Optional feature macro: UART_TX_PARITY_EN -- when defined, a PARITY state
// sends the XOR of the data bits between DATA and STOP (11-bit frame);
// otherwise DATA goes straight to STOP (10-bit frame).
// Frames are sent back to back while the FIFO holds data.
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [DIV_W-1:0] PERIOD_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(UART_DATA_BITS - 1);

    // FIFO interface
    logic [UART_DATA_BITS-1:0]       fifo_rdata;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;

    // Transmitter state
    uart_tx_state_t                  state_q;
    logic                            tx_q;
    logic [UART_DATA_BITS-1:0]       shift_q;
    logic [BIT_W-1:0]                bit_q;
    logic [DIV_W-1:0]                period_q;
`ifdef UART_TX_PARITY_EN
    logic                            parity_q;
`endif

    // Decode signals
    logic                            period_end;
    logic                            pop_d;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .srst  (i_rst),
        .push  (i_valid),
        .pop   (pop_d),
        .wdata (i_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign period_end = (period_q == PERIOD_LAST);

    // A new frame starts from IDLE, or right at the end of a stop bit, when a byte is waiting.
    always_comb begin
        pop_d = 1'b0;
        if (!fifo_empty) begin
            if (state_q == IDLE) begin
                pop_d = 1'b1;
            end else if ((state_q == STOP) && period_end) begin
                pop_d = 1'b1;
            end
        end
    end

    // Frame sequencer: state, bit/period counters and the registered serial output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            tx_q     <= UART_IDLE_LEVEL;
            shift_q  <= '0;
            bit_q    <= '0;
            period_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (pop_d) begin
            // Load the FIFO head and drive the start bit from this edge.
            state_q  <= START;
            tx_q     <= ~UART_IDLE_LEVEL;
            shift_q  <= fifo_rdata;
            bit_q    <= '0;
            period_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= uart_even_parity(fifo_rdata);
`endif
        end else begin
            // Period counter reloads on every bit boundary.
            if (state_q == IDLE || period_end) begin
                period_q <= '0;
            end else begin
                period_q <= period_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    tx_q <= UART_IDLE_LEVEL;
                end

                START: begin
                    if (period_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end

                DATA: begin
                    if (period_end) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            // Shift right so bit 0 always holds the bit on the line.
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (period_end) begin
                        state_q <= STOP;
                        tx_q    <= UART_IDLE_LEVEL;
                    end
                end
`endif

                STOP: begin
                    // Back-to-back frames are handled by the pop_d branch above.
                    if (period_end) begin
                        state_q <= IDLE;
                        tx_q    <= UART_IDLE_LEVEL;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    tx_q    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    assign o_tx         = tx_q;
    assign o_ready      = !fifo_full;
    assign o_fifo_count = fifo_count;
    assign o_busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (CLK_DIV=4, FIFO_DEPTH=4).
// A cycle-level reference model (byte queue + "cycles left in current frame")
// predicts o_tx/o_ready/o_busy/o_fifo_count and pushes every accepted byte into
// a scoreboard queue; an independent line decoder pops and compares whole frames.
module tb_uart_tx_fifo;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CLK_DIV;

    logic          clk;
    logic          rst;
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fcount;

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_fifo_count (fcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    logic [7:0]  exp_q[$];
    int          m_rem = 0;
    logic [10:0] m_bits = '1;
    int          accepted = 0;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        f[FRAME_BITS - 1] = 1'b1;
        return f;
    endfunction

    always @(posedge clk) begin
        int  size_before;
        bit  start;
        logic [7:0] b;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_rem = 0;
        end else begin
            size_before = m_q.size();
            start = 1'b0;
            if (m_rem > 1) begin
                m_rem = m_rem - 1;
            end else begin
                m_rem = 0;
                start = (size_before > 0);
            end
            if (start) begin
                b = m_q.pop_front();
                m_bits = frame_of(b);
                m_rem = FRAME;
            end
            if (valid && size_before < FIFO_DEPTH) begin
                m_q.push_back(data);
                exp_q.push_back(data);
                accepted++;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int exp_tx;
        if (started) begin
            exp_tx = (m_rem == 0) ? 1 : int'(m_bits[(FRAME - m_rem) / CLK_DIV]);
            chk("tx_level", int'(tx), exp_tx);
            chk("fifo_count", int'(fcount), m_q.size());
            chk("ready", int'(ready), int'(m_q.size() < FIFO_DEPTH));
            chk("busy", int'(busy), int'(m_rem != 0 || m_q.size() != 0));
        end
    end

    // ---------------- line decoder / scoreboard ----------------
    int          d_idx = -1;
    logic [10:0] d_bits;
    int          n_frames = 0;
    logic [7:0]  dec_log[$];
    logic        last_par = 1'b0;

    always @(negedge clk) begin
        int bi;
        logic [7:0] got;
        if (started) begin
            if (rst) begin
                d_idx = -1;
            end else begin
                if (d_idx < 0 && tx == 1'b0) d_idx = 0;
                if (d_idx >= 0) begin
                    bi = d_idx / CLK_DIV;
                    if (d_idx % CLK_DIV == 0) d_bits[bi] = tx;
                    else chk("bit_stable", int'(tx), int'(d_bits[bi]));
                    d_idx++;
                    if (d_idx == FRAME) begin
                        d_idx = -1;
                        n_frames++;
                        got = d_bits[8:1];
                        dec_log.push_back(got);
                        chk("stop_bit", int'(d_bits[FRAME_BITS - 1]), 1);
`ifdef UART_TX_PARITY_EN
                        last_par = d_bits[9];
                        chk("parity_bit", int'(d_bits[9]), int'(^got));
`endif
                        if (exp_q.size() == 0) chk("unexpected_frame", int'(got), -1);
                        else chk("frame_byte", int'(got), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        cyc();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((m_rem != 0 || m_q.size() != 0 || d_idx >= 0) && n < limit) begin
            cyc();
            n++;
        end
        cyc();
        chk("drain_timeout", int'(n < limit), 1);
    endtask

    // Push one byte while idle and count sampled cycles with o_busy high.
    task automatic send_measure(input logic [7:0] b, output int busy_cycles);
        int n;
        push(b);
        busy_cycles = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            busy_cycles++;
            n++;
            @(negedge clk);
        end
        cyc();
    endtask

    initial begin
        int f0;
        int bc;
        int base;
        int n;
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        repeat (3) cyc();
        rst = 1'b0;
        started = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fcount), 0);
        cyc();

        // Single byte 0x55: busy spans accept edge through end of stop bit
        f0 = n_frames;
        send_measure(8'h55, bc);
        chk("t1_busy_cycles", bc, FRAME + 1);
        wait_idle(200);
        chk("t1_frames", n_frames - f0, 1);
        chk("t1_byte", int'(dec_log[dec_log.size() - 1]), 'h55);

        // Two bytes on consecutive cycles -> back-to-back frames
        f0 = n_frames;
        valid = 1'b1;
        data = 8'hA3;
        cyc();
        data = 8'h0F;
        cyc();
        valid = 1'b0;
        wait_idle(300);
        chk("t2_frames", n_frames - f0, 2);
        chk("t2_first", int'(dec_log[dec_log.size() - 2]), 'hA3);
        chk("t2_second", int'(dec_log[dec_log.size() - 1]), 'h0F);

        // Hold valid 8 cycles while idle: 1 popped + 4 queued, rest dropped
        f0 = n_frames;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'(8'h10 + i);
            cyc();
        end
        valid = 1'b0;
        @(negedge clk);
        chk("t3_count_full", int'(fcount), FIFO_DEPTH);
        chk("t3_ready_low", int'(ready), 0);
        wait_idle(600);
        chk("t3_frames", n_frames - f0, 5);
        for (int i = 0; i < 5; i++)
            chk("t3_order", int'(dec_log[dec_log.size() - 5 + i]), 'h10 + i);

        // Reset during data bit 3 of 0xFF with two bytes queued
        f0 = n_frames;
        push(8'hFF);
        push(8'h11);
        push(8'h22);
        n = 0;
        while (!(m_rem > 0 && (FRAME - m_rem) / CLK_DIV == 4) && n < 100) begin
            cyc();
            n++;
        end
        chk("t4_reach_bit3", int'(n < 100), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_tx", int'(tx), 1);
        chk("t4_count", int'(fcount), 0);
        chk("t4_busy", int'(busy), 0);
        repeat (3 * FRAME) cyc();
        chk("t4_no_frames", n_frames - f0, 0);

`ifdef UART_TX_PARITY_EN
        // Parity bit and 11-bit frame length
        send_measure(8'h07, bc);
        wait_idle(200);
        chk("t5_par_07", int'(last_par), 1);
        chk("t5_frame_len", bc, 11 * CLK_DIV + 1);
        send_measure(8'h03, bc);
        wait_idle(200);
        chk("t5_par_03", int'(last_par), 0);
`endif

        // Random pushes with back-pressure: 1000 bytes
        f0 = n_frames;
        base = accepted;
        n = 0;
        while (accepted - base < 1000 && n < 60000) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
            cyc();
            n++;
        end
        valid = 1'b0;
        chk("t6_accepted", accepted - base, 1000);
        wait_idle(FRAME * (FIFO_DEPTH + 2));
        chk("t6_frames", n_frames - f0, 1000);
        chk("t6_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #(900000 * 1ns);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
